hardwired_control_sequencer: RTL and testbench



---
 rtl/hardwired_control_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_hardwired_control_sequencer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hardwired_control_sequencer.sv
// Hardwired fetch/execute control sequencer for the 32-bit datapath.
// Optional HI/LO move instructions are enabled by defining CTRL_HILO_MOVE_EN.
module hardwired_control_sequencer #(
  parameter int unsigned         MEM_WAIT = 0,
  parameter int unsigned         ALU_OP_W = 5,
  parameter logic [ALU_OP_W-1:0] ADD_CODE = ALU_OP_W'(1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         IR_Data,
  input  logic                stop,
  output logic                PC_select,
  output logic                MAR_enable,
  output logic                PC_increment_enable,
  output logic                read,
  output logic                MDR_enable,
  output logic                MDR_select,
  output logic                IR_enable,
  output logic                Gra,
  output logic                Grb,
  output logic                Grc,
  output logic                BAout,
  output logic                r_select,
  output logic                r_enable,
  output logic                Y_enable,
  output logic                Z_enable,
  output logic                Z_LO_select,
  output logic                c_select,
  output logic                HI_enable,
  output logic                HI_select,
  output logic                LO_enable,
  output logic                LO_select,
  output logic [ALU_OP_W-1:0] alu_instruction,
  output logic                run,
  output logic [3:0]          step
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_T0      = 4'd1,
    S_T1      = 4'd2,
    S_T2      = 4'd3,
    S_T3      = 4'd4,
    S_T4      = 4'd5,
    S_T5      = 4'd6,
    S_STOPPED = 4'd7,
    S_HALTED  = 4'd8
  } state_e;

  typedef enum logic [2:0] {
    OP_RTYPE, OP_ADDI, OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO, OP_HALT, OP_NOP
  } op_class_e;

  localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

  state_e     state_q, state_d;
  logic [2:0] wait_cnt_q, wait_cnt_d;
  op_class_e  op_class;
  logic [4:0] opcode;
  logic       unused_ir;

  assign opcode    = IR_Data[31:27];
  assign unused_ir = ^IR_Data[26:0];

  always_comb begin
    op_class = OP_NOP;
    if (opcode <= 5'b01011)      op_class = OP_RTYPE;
    else if (opcode == 5'b01100) op_class = OP_ADDI;
    else if (opcode == 5'b11111) op_class = OP_HALT;
`ifdef CTRL_HILO_MOVE_EN
    else if (opcode == 5'b11000) op_class = OP_MFHI;
    else if (opcode == 5'b11001) op_class = OP_MFLO;
    else if (opcode == 5'b11010) op_class = OP_MTHI;
    else if (opcode == 5'b11011) op_class = OP_MTLO;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    unique case (state_q)
      S_IDLE:    if (!stop) state_d = S_T0;
      S_T0:      state_d = S_T1;
      S_T1: begin
        if (wait_cnt_q == WAIT_LAST) state_d = S_T2;
        else                         wait_cnt_d = 3'(wait_cnt_q + 3'd1);
      end
      S_T2:      state_d = S_T3;
      S_T3: begin
        if (op_class == OP_HALT)                            state_d = S_HALTED;
        else if (op_class == OP_RTYPE || op_class == OP_ADDI) state_d = S_T4;
        else                                                state_d = stop ? S_STOPPED : S_T0;
      end
      S_T4:      state_d = S_T5;
      S_T5:      state_d = stop ? S_STOPPED : S_T0;
      S_STOPPED: if (!stop) state_d = S_T0;
      S_HALTED:  state_d = S_HALTED;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    PC_select           = 1'b0;
    MAR_enable          = 1'b0;
    PC_increment_enable = 1'b0;
    read                = 1'b0;
    MDR_enable          = 1'b0;
    MDR_select          = 1'b0;
    IR_enable           = 1'b0;
    Gra                 = 1'b0;
    Grb                 = 1'b0;
    Grc                 = 1'b0;
    BAout               = 1'b0;
    r_select            = 1'b0;
    r_enable            = 1'b0;
    Y_enable            = 1'b0;
    Z_enable            = 1'b0;
    Z_LO_select         = 1'b0;
    c_select            = 1'b0;
    HI_enable           = 1'b0;
    HI_select           = 1'b0;
    LO_enable           = 1'b0;
    LO_select           = 1'b0;
    alu_instruction     = '0;
    unique case (state_q)
      S_T0: begin
        PC_select  = 1'b1;
        MAR_enable = 1'b1;
      end
      S_T1: begin
        // PC must advance once per fetch even when T1 is stretched.
        PC_increment_enable = (wait_cnt_q == 3'd0);
        read                = 1'b1;
        MDR_enable          = 1'b1;
      end
      S_T2: begin
        MDR_select = 1'b1;
        IR_enable  = 1'b1;
      end
      S_T3: begin
        unique case (op_class)
          OP_RTYPE: begin Grb = 1'b1; r_select = 1'b1; Y_enable = 1'b1; end
          OP_ADDI:  begin Grb = 1'b1; BAout = 1'b1; Y_enable = 1'b1; end
          OP_MFHI:  begin Gra = 1'b1; r_enable = 1'b1; HI_select = 1'b1; end
          OP_MFLO:  begin Gra = 1'b1; r_enable = 1'b1; LO_select = 1'b1; end
          OP_MTHI:  begin Gra = 1'b1; r_select = 1'b1; HI_enable = 1'b1; end
          OP_MTLO:  begin Gra = 1'b1; r_select = 1'b1; LO_enable = 1'b1; end
          default:  ;
        endcase
      end
      S_T4: begin
        Z_enable = 1'b1;
        if (op_class == OP_ADDI) begin
          c_select        = 1'b1;
          alu_instruction = ADD_CODE;
        end else begin
          Grc             = 1'b1;
          r_select        = 1'b1;
          alu_instruction = ALU_OP_W'(opcode);
        end
      end
      S_T5: begin
        Z_LO_select = 1'b1;
        Gra         = 1'b1;
        r_enable    = 1'b1;
      end
      default: ;
    endcase
  end

  assign run  = !(state_q == S_IDLE || state_q == S_STOPPED || state_q == S_HALTED);
  assign step = state_q;

endmodule

// File: tb/tb_hardwired_control_sequencer.sv
// Directed vector bench for hardwired_control_sequencer (MEM_WAIT=0 and 3 instances).
module tb_hardwired_control_sequencer;

  // Control bundle bit positions, MSB first.
  localparam logic [20:0] PCSEL  = 21'h1 << 20;
  localparam logic [20:0] MAR    = 21'h1 << 19;
  localparam logic [20:0] PCINC  = 21'h1 << 18;
  localparam logic [20:0] RD     = 21'h1 << 17;
  localparam logic [20:0] MDREN  = 21'h1 << 16;
  localparam logic [20:0] MDRSEL = 21'h1 << 15;
  localparam logic [20:0] IREN   = 21'h1 << 14;
  localparam logic [20:0] GRA    = 21'h1 << 13;
  localparam logic [20:0] GRB    = 21'h1 << 12;
  localparam logic [20:0] GRC    = 21'h1 << 11;
  localparam logic [20:0] BAO    = 21'h1 << 10;
  localparam logic [20:0] RSEL   = 21'h1 << 9;
  localparam logic [20:0] REN    = 21'h1 << 8;
  localparam logic [20:0] YEN    = 21'h1 << 7;
  localparam logic [20:0] ZEN    = 21'h1 << 6;
  localparam logic [20:0] ZLO    = 21'h1 << 5;
  localparam logic [20:0] CSEL   = 21'h1 << 4;
  localparam logic [20:0] HIEN   = 21'h1 << 3;
  localparam logic [20:0] HISEL  = 21'h1 << 2;
  localparam logic [20:0] LOEN   = 21'h1 << 1;
  localparam logic [20:0] LOSEL  = 21'h1 << 0;

`ifdef CTRL_HILO_MOVE_EN
  localparam logic [20:0] EXP_MFHI = GRA | REN | HISEL;
  localparam logic [20:0] EXP_MFLO = GRA | REN | LOSEL;
  localparam logic [20:0] EXP_MTHI = GRA | RSEL | HIEN;
  localparam logic [20:0] EXP_MTLO = GRA | RSEL | LOEN;
`else
  localparam logic [20:0] EXP_MFHI = 21'd0;
  localparam logic [20:0] EXP_MFLO = 21'd0;
  localparam logic [20:0] EXP_MTHI = 21'd0;
  localparam logic [20:0] EXP_MTLO = 21'd0;
`endif

  localparam logic [31:0] IR_ADDI = 32'h6200_0005;
  localparam logic [31:0] IR_R03  = 32'h1800_0000;
  localparam logic [31:0] IR_R05  = 32'h2800_0000;
  localparam logic [31:0] IR_R0B  = 32'h5800_0000;
  localparam logic [31:0] IR_MFHI = 32'hC180_0000;
  localparam logic [31:0] IR_MFLO = 32'hC800_0000;
  localparam logic [31:0] IR_MTHI = 32'hD000_0000;
  localparam logic [31:0] IR_MTLO = 32'hD800_0000;
  localparam logic [31:0] IR_NOP  = 32'h8000_0000;
  localparam logic [31:0] IR_HALT = 32'hF800_0000;

  typedef struct {
    logic [31:0] ir;
    logic        stop;
    logic [3:0]  step;
    logic [20:0] ctrl;
    logic [4:0]  alu;
    logic        run;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] ir0 = '0, ir3 = '0;
  logic        stop0 = 1'b0, stop3 = 1'b1;
  logic [20:0] ctrl0, ctrl3;
  logic [4:0]  alu0, alu3;
  logic        run0, run3;
  logic [3:0]  step0, step3;

  int n_vec = 0;
  int n_bad = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  hardwired_control_sequencer #(.MEM_WAIT(0)) u_dut0 (
    .clk(clk), .reset(reset), .IR_Data(ir0), .stop(stop0),
    .PC_select(ctrl0[20]), .MAR_enable(ctrl0[19]), .PC_increment_enable(ctrl0[18]),
    .read(ctrl0[17]), .MDR_enable(ctrl0[16]), .MDR_select(ctrl0[15]), .IR_enable(ctrl0[14]),
    .Gra(ctrl0[13]), .Grb(ctrl0[12]), .Grc(ctrl0[11]), .BAout(ctrl0[10]),
    .r_select(ctrl0[9]), .r_enable(ctrl0[8]), .Y_enable(ctrl0[7]), .Z_enable(ctrl0[6]),
    .Z_LO_select(ctrl0[5]), .c_select(ctrl0[4]), .HI_enable(ctrl0[3]), .HI_select(ctrl0[2]),
    .LO_enable(ctrl0[1]), .LO_select(ctrl0[0]),
    .alu_instruction(alu0), .run(run0), .step(step0)
  );

  hardwired_control_sequencer #(.MEM_WAIT(3)) u_dut3 (
    .clk(clk), .reset(reset), .IR_Data(ir3), .stop(stop3),
    .PC_select(ctrl3[20]), .MAR_enable(ctrl3[19]), .PC_increment_enable(ctrl3[18]),
    .read(ctrl3[17]), .MDR_enable(ctrl3[16]), .MDR_select(ctrl3[15]), .IR_enable(ctrl3[14]),
    .Gra(ctrl3[13]), .Grb(ctrl3[12]), .Grc(ctrl3[11]), .BAout(ctrl3[10]),
    .r_select(ctrl3[9]), .r_enable(ctrl3[8]), .Y_enable(ctrl3[7]), .Z_enable(ctrl3[6]),
    .Z_LO_select(ctrl3[5]), .c_select(ctrl3[4]), .HI_enable(ctrl3[3]), .HI_select(ctrl3[2]),
    .LO_enable(ctrl3[1]), .LO_select(ctrl3[0]),
    .alu_instruction(alu3), .run(run3), .step(step3)
  );

  // Packed view: {step, ctrl, alu, run}.
  task automatic check(input string name, input bit inst3, input logic [3:0] st,
                       input logic [20:0] c, input logic [4:0] a, input logic r);
    logic [30:0] act, exp;
    act = inst3 ? {step3, ctrl3, alu3, run3} : {step0, ctrl0, alu0, run0};
    exp = {st, c, a, r};
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got step=%0d ctrl=%h alu=%h run=%b, want step=%0d ctrl=%h alu=%h run=%b",
               name, act[30:27], act[26:6], act[5:1], act[0], st, c, a, r);
    end
  endtask

  task automatic push(input logic [31:0] ir, input logic stp, input logic [3:0] st,
                      input logic [20:0] c, input logic [4:0] a, input logic r);
    vec_t v;
    v.ir = ir; v.stop = stp; v.step = st; v.ctrl = c; v.alu = a; v.run = r;
    vecs.push_back(v);
  endtask

  task automatic push_fetch(input logic [31:0] ir);
    push(ir, 1'b0, 4'd1, PCSEL | MAR, 5'd0, 1'b1);
    push(ir, 1'b0, 4'd2, PCINC | RD | MDREN, 5'd0, 1'b1);
    push(ir, 1'b0, 4'd3, MDRSEL | IREN, 5'd0, 1'b1);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check("reset_dut0", 1'b0, 4'd0, 21'd0, 5'd0, 1'b0);
    check("reset_dut3", 1'b1, 4'd0, 21'd0, 5'd0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // addi, then max-code R-type, then one-step instructions and a NOP.
    push(IR_ADDI, 1'b0, 4'd0, 21'd0, 5'd0, 1'b0);
    push_fetch(IR_ADDI);
    push(IR_ADDI, 1'b0, 4'd4, GRB | BAO | YEN, 5'd0, 1'b1);
    push(IR_ADDI, 1'b0, 4'd5, CSEL | ZEN, 5'b00001, 1'b1);
    push(IR_ADDI, 1'b0, 4'd6, ZLO | GRA | REN, 5'd0, 1'b1);
    push_fetch(IR_R03);
    push(IR_R03, 1'b0, 4'd4, GRB | RSEL | YEN, 5'd0, 1'b1);
    push(IR_R03, 1'b0, 4'd5, GRC | RSEL | ZEN, 5'b00011, 1'b1);
    push(IR_R03, 1'b0, 4'd6, ZLO | GRA | REN, 5'd0, 1'b1);
    push_fetch(IR_R0B);
    push(IR_R0B, 1'b0, 4'd4, GRB | RSEL | YEN, 5'd0, 1'b1);
    push(IR_R0B, 1'b0, 4'd5, GRC | RSEL | ZEN, 5'b01011, 1'b1);
    push(IR_R0B, 1'b0, 4'd6, ZLO | GRA | REN, 5'd0, 1'b1);
    push_fetch(IR_MFHI);
    push(IR_MFHI, 1'b0, 4'd4, EXP_MFHI, 5'd0, 1'b1);
    push_fetch(IR_MFLO);
    push(IR_MFLO, 1'b0, 4'd4, EXP_MFLO, 5'd0, 1'b1);
    push_fetch(IR_MTHI);
    push(IR_MTHI, 1'b0, 4'd4, EXP_MTHI, 5'd0, 1'b1);
    push_fetch(IR_MTLO);
    push(IR_MTLO, 1'b0, 4'd4, EXP_MTLO, 5'd0, 1'b1);
    push_fetch(IR_NOP);
    push(IR_NOP, 1'b0, 4'd4, 21'd0, 5'd0, 1'b1);
    push(IR_NOP, 1'b0, 4'd1, PCSEL | MAR, 5'd0, 1'b1);

    reset = 1'b1;
    #1;
    check("reset_dut0", 1'b0, 4'd0, 21'd0, 5'd0, 1'b0);
    check("reset_dut3", 1'b1, 4'd0, 21'd0, 5'd0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    foreach (vecs[i]) begin
      ir0   = vecs[i].ir;
      stop0 = vecs[i].stop;
      #2;
      check($sformatf("vec%0d", i), 1'b0, vecs[i].step, vecs[i].ctrl, vecs[i].alu, vecs[i].run);
      @(posedge clk);
      #1;
    end
    check("dut3_parked_idle", 1'b1, 4'd0, 21'd0, 5'd0, 1'b0);

    // Asynchronous reset in the middle of addi T4.
    do_reset();
    ir0 = IR_ADDI; stop0 = 1'b0;
    cyc(5);
    check("addi_t4_pre_reset", 1'b0, 4'd5, CSEL | ZEN, 5'b00001, 1'b1);
    reset = 1'b1;
    #1;
    check("reset_no_clock", 1'b0, 4'd0, 21'd0, 5'd0, 1'b0);
    #1;
    reset = 1'b0;
    cyc(1);
    check("t0_after_reset", 1'b0, 4'd1, PCSEL | MAR, 5'd0, 1'b1);

    // stop raised during T1 of an R-type instruction.
    ir0 = IR_R05;
    cyc(1);
    stop0 = 1'b1;
    cyc(4);
    check("stop_t5_completes", 1'b0, 4'd6, ZLO | GRA | REN, 5'd0, 1'b1);
    cyc(1);
    check("stopped_entry", 1'b0, 4'd7, 21'd0, 5'd0, 1'b0);
    cyc(2);
    check("stopped_hold", 1'b0, 4'd7, 21'd0, 5'd0, 1'b0);
    stop0 = 1'b0;
    #2;
    check("stopped_before_edge", 1'b0, 4'd7, 21'd0, 5'd0, 1'b0);
    cyc(1);
    check("t0_after_stop", 1'b0, 4'd1, PCSEL | MAR, 5'd0, 1'b1);

    // halt parks until reset.
    ir0 = IR_HALT;
    cyc(3);
    check("halt_t3", 1'b0, 4'd4, 21'd0, 5'd0, 1'b1);
    cyc(1);
    check("halted_entry", 1'b0, 4'd8, 21'd0, 5'd0, 1'b0);
    cyc(20);
    check("halted_hold", 1'b0, 4'd8, 21'd0, 5'd0, 1'b0);
    do_reset();
    cyc(1);
    check("t0_after_halt_reset", 1'b0, 4'd1, PCSEL | MAR, 5'd0, 1'b1);

    // MEM_WAIT=3: T1 stretched to 4 cycles, one PC increment.
    ir3 = IR_NOP; stop3 = 1'b0;
    cyc(1);
    check("mw3_t0", 1'b1, 4'd1, PCSEL | MAR, 5'd0, 1'b1);
    cyc(1);
    check("mw3_t1_first", 1'b1, 4'd2, PCINC | RD | MDREN, 5'd0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      check($sformatf("mw3_t1_wait%0d", k), 1'b1, 4'd2, RD | MDREN, 5'd0, 1'b1);
    end
    cyc(1);
    check("mw3_t2", 1'b1, 4'd3, MDRSEL | IREN, 5'd0, 1'b1);
    cyc(1);
    check("mw3_t3_nop", 1'b1, 4'd4, 21'd0, 5'd0, 1'b1);
    cyc(1);
    check("mw3_next_t0", 1'b1, 4'd1, PCSEL | MAR, 5'd0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
